// File: rtl/scr1_tcm_dma_engine.sv
// Block-transfer engine for TCM port B: reads a run of words, optionally transforms them
// (add/XOR constant or sum-reduce) and writes the results back while the core is stalled.
module scr1_tcm_dma_engine #(
    parameter int AW = 14,
    parameter int LW = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    input  logic [1:0]    op_i,
    input  logic [AW-1:0] src_i,
    input  logic [AW-1:0] dst_i,
    input  logic [LW-1:0] len_i,
    input  logic [31:0]   konst_i,
    input  logic          core_dmem_req_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [31:0]   result_o,
    output logic          port_own_o,
    output logic          core_stall_o,
    output logic          mem_ren_o,
    output logic          mem_wen_o,
    output logic [3:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [31:0]   mem_wdata_o,
    input  logic [31:0]   mem_rdata_i
);

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_READ, S_XFER, S_SUMWR, S_DONE} state_e;
    typedef enum logic [1:0] {OP_COPY, OP_ADDK, OP_XORK, OP_SUM} op_e;

    state_e        state_q;
    op_e           op_q;
    logic [AW-1:0] rp_q, wp_q, dst_q;
    logic [LW-1:0] cnt_q;
    logic [31:0]   konst_q, acc_q, result_q;
    logic [31:0]   acc_d, xfer_data_d;

    // The core request only feeds status; the stall is unconditional while the engine is active.
    logic unused_core_req;
    assign unused_core_req = core_dmem_req_i;

    assign acc_d = acc_q + mem_rdata_i;

    always_comb begin
        unique case (op_q)
            OP_ADDK: xfer_data_d = mem_rdata_i + konst_q;
            OP_XORK: xfer_data_d = mem_rdata_i ^ konst_q;
            default: xfer_data_d = mem_rdata_i;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_COPY;
            rp_q     <= '0;
            wp_q     <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            konst_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        op_q    <= op_e'(op_i);
                        rp_q    <= src_i;
                        wp_q    <= dst_i;
                        dst_q   <= dst_i;
                        cnt_q   <= len_i;
                        konst_q <= konst_i;
                        acc_q   <= '0;
                        state_q <= (len_i == '0) ? S_DONE : S_ARB;
                    end
                end
                S_ARB: state_q <= S_READ;
                S_READ: begin
                    rp_q    <= rp_q + AW'(1);
                    state_q <= S_XFER;
                end
                S_XFER: begin
                    if (op_q == OP_SUM) acc_q <= acc_d;
                    else                wp_q  <= wp_q + AW'(1);
                    cnt_q <= cnt_q - LW'(1);
                    if (cnt_q == LW'(1)) state_q <= (op_q == OP_SUM) ? S_SUMWR : S_DONE;
                    else                 state_q <= S_READ;
                end
                S_SUMWR: begin
                    result_q <= acc_q;
                    state_q  <= S_DONE;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = (state_q == S_DONE);
    assign result_o     = result_q;
    assign port_own_o   = (state_q == S_READ) || (state_q == S_XFER) || (state_q == S_SUMWR);
    assign core_stall_o = (state_q == S_ARB) || port_own_o;
    assign mem_ren_o    = (state_q == S_READ);
    assign mem_wen_o    = ((state_q == S_XFER) && (op_q != OP_SUM)) || (state_q == S_SUMWR);
    assign mem_be_o     = {4{mem_wen_o}};

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            S_READ: mem_addr_o = rp_q;
            S_XFER: begin
                if (op_q != OP_SUM) begin
                    mem_addr_o  = wp_q;
                    mem_wdata_o = xfer_data_d;
                end
            end
            S_SUMWR: begin
                mem_addr_o  = dst_q;
                mem_wdata_o = acc_q;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/scr1_tcm_dma_engine.md
# scr1_tcm_dma_engine

Block-transfer engine that drives the data port (port B) of the tightly-coupled memory when the core is not using it. It reads a run of 32-bit words, optionally transforms them (add constant, XOR constant, or sum-reduce), and writes the results back into the same memory. It sits directly upstream of the memory's port-B mux: `port_own` selects the engine over the core, and `core_stall` holds off new core data requests while the engine owns the port.

## Interface
- `AW`, 14: word-address width; addresses wrap modulo 2^AW.
- `LW`, 15: transfer-length width, in words.
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: one-cycle command strobe; sampled only in IDLE.
- `op`, in, 2: operation. 0 = COPY, 1 = ADDK, 2 = XORK, 3 = SUM.
- `src`, in, AW: source word address.
- `dst`, in, AW: destination word address.
- `len`, in, LW: number of words.
- `konst`, in, 32: operand for ADDK and XORK.
- `core_dmem_req`, in, 1: the core's data request; used only for status.
- `busy`, out, 1: high from ARB through DONE inclusive.
- `done`, out, 1: one-cycle pulse in the DONE state.
- `result`, out, 32: final accumulator of the last SUM; holds its value until the next SUM starts.
- `port_own`, out, 1: engine owns port B; high in READ, XFER and SUMWR.
- `core_stall`, out, 1: gates the core's data `req_ack` low; high in ARB, READ, XFER and SUMWR.
- `mem_ren`, out, 1: port-B read enable.
- `mem_wen`, out, 1: port-B write enable.
- `mem_be`, out, 4: byte enables; always 4'b1111 when `mem_wen` is high, else 0.
- `mem_addr`, out, AW: port-B word address.
- `mem_wdata`, out, 32: port-B write data.
- `mem_rdata`, in, 32: port-B read data, valid the cycle after `mem_ren`.

## Operation
- States: IDLE, ARB, READ, XFER, SUMWR, DONE.
- Latched at `start`: `op`, `src`, `dst`, `len`, `konst`.
  - The engine holds a word counter `cnt`, a read pointer `rp`, a write pointer `wp` and a 32-bit accumulator `acc`.
- IDLE:
  - `start` with `len`==0 → DONE. No ARB, no memory access, `port_own` never asserts.
  - `start` with `len`>0 → ARB.
- ARB lasts exactly one cycle and is the quiesce cycle.
  - `core_stall` blocks new core acceptance.
  - A core access accepted in the preceding cycle completes its response in this cycle.
  - Next state: READ.
- READ: `mem_ren`=1, `mem_addr`=`rp`; `rp` increments. Next state: XFER.
- XFER: `mem_rdata` is valid in this cycle.
  - COPY/ADDK/XORK:
    - Write `mem_wen`=1, `mem_addr`=`wp`, `mem_wdata`=f(`mem_rdata`).
    - f is: identity for COPY; `rdata+konst` modulo 2^32 for ADDK; `rdata^konst` for XORK.
    - `wp` increments.
  - SUM: `acc` <= `acc`+`rdata` modulo 2^32; no write.
  - `cnt` decrements. If `cnt` reaches 0 → DONE (SUMWR for SUM); otherwise → READ.
- SUMWR: write `acc` to `dst`; `result` <= `acc`. Next state: DONE.
- DONE: `done`=1, `core_stall`=0, `port_own`=0. Next state: IDLE.
- `start` in any state other than IDLE is ignored. No queueing, no error flag.
- Addresses:
  - `rp` and `wp` wrap from 2^AW-1 to 0.
  - Overlapping regions are processed in ascending order.
  - Results are defined when `dst`<=`src` or the regions do not overlap.
- `acc` clears to 0 when a SUM is accepted.
- `result` is not updated by COPY, ADDK or XORK.
- Reset mid-operation:
  - Return to IDLE at once; all outputs go to 0.
  - Words already written stay written; the in-flight write is dropped; no `done` pulse.

## Timing
- Reset value of every output is 0, including `result`.
- All control outputs decode the registered state. `mem_wdata` is combinational from `mem_rdata` in XFER.
- With `start` high at cycle 0 and `len`=N>0:
  - ARB is at cycle 1.
  - READ_i is at cycle 2+2i and XFER_i at cycle 3+2i.
  - COPY/ADDK/XORK: DONE at cycle 2N+2.
  - SUM: SUMWR at cycle 2N+2, DONE at cycle 2N+3.
- `len`=0: DONE at cycle 1.
- Throughput is 2 cycles per word.
- `mem_ren` and `mem_wen` are never high in the same cycle.
- The earliest accepted `start` after DONE is the cycle after DONE, when the engine is back in IDLE.
- `core_stall` drops in the same cycle that `done` rises, so the core can issue in DONE.

## Test plan
- COPY, `src`=0x010, `dst`=0x100, `len`=4, memory[0x10..0x13]=1,2,3,4 → memory[0x100..0x103]=1,2,3,4.
  - `done` at cycle 10.
  - `port_own` high in cycles 2..9.
- ADDK, `konst`=1, word 0xFFFFFFFF, `len`=1 → written 0x00000000; word 0x7FFFFFFF → written 0x80000000.
- SUM over 3 words 0xFFFFFFFF, 2, 5, `dst`=0x20 → memory[0x20]=0x00000006 and `result`=6; `done` at cycle 9.
- `len`=0 → `done` at cycle 1; `mem_ren`, `mem_wen` and `port_own` never assert; `core_stall` never asserts.
- Core request in the cycle before and during ARB → the prior request completes in ARB; the ARB-cycle request sees `req_ack`=0 until DONE.
  - A second `start` pulse while busy has no effect.
- COPY, `src`=0x3FFE, `len`=4, AW=14 → reads 0x3FFE, 0x3FFF, 0x0000, 0x0001.
  - `rst_n` pulsed low during XFER_2 → outputs 0 immediately; only words 0 and 1 written; no `done`.
